// File: rtl/tmr_icb_slave.sv
// ICB slave front-end for the 16-bit timer: decodes single-beat commands into
// one-cycle timer write strobes and serves register reads, one transaction at a time.
//
// state | meaning
// IDLE  | ready for a command (cmd_ready high unless in reset)
// RESP  | response presented, waiting for rsp_ready
module tmr_icb_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter logic [11:0] CON_OFS   = 12'h000,
    parameter logic [11:0] PRD_OFS   = 12'h004,
    parameter logic [11:0] CNT_OFS   = 12'h008
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        icb_cmd_valid,
    output logic        icb_cmd_ready,
    input  logic [31:0] icb_cmd_addr,
    input  logic        icb_cmd_read,
    input  logic [31:0] icb_cmd_wdata,
    input  logic [3:0]  icb_cmd_wmask,
    output logic        icb_rsp_valid,
    input  logic        icb_rsp_ready,
    output logic [31:0] icb_rsp_rdata,
    output logic        icb_rsp_err,
    output logic        tmr_con_wr,
    output logic        tmr_prd_wr,
    output logic        tmr_cnt_wr,
    output logic [15:0] icb_wdat,
    input  logic [15:0] tmr_con,
    input  logic [15:0] tmr_prd,
    input  logic [15:0] tmr_cnt
);

    typedef enum logic {IDLE, RESP} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic        hit, sel_con, sel_prd, sel_cnt, addr_ok, req_ok;
    logic [11:0] ofs;
    logic [15:0] rd_val;
    logic        con_wr_q, prd_wr_q, cnt_wr_q;
    logic        unused_bits;

    assign unused_bits = ^{icb_cmd_wdata[31:16], icb_cmd_wmask[3:2]};

    assign accept = icb_cmd_valid & (state == IDLE) & ~sys_rst;

    assign hit     = (icb_cmd_addr[31:12] == BASE_ADDR[31:12]);
    assign ofs     = icb_cmd_addr[11:0];
    assign sel_con = (ofs == CON_OFS);
    assign sel_prd = (ofs == PRD_OFS);
    assign sel_cnt = (ofs == CNT_OFS);
    assign addr_ok = hit & (sel_con | sel_prd | sel_cnt) & (icb_cmd_addr[1:0] == 2'b00);
    assign req_ok  = addr_ok & (icb_cmd_read | (icb_cmd_wmask[1:0] == 2'b11));

    always_comb begin
        rd_val = 16'h0;
        if (sel_con)      rd_val = tmr_con;
        else if (sel_prd) rd_val = tmr_prd;
        else if (sel_cnt) rd_val = tmr_cnt;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        icb_cmd_ready = 1'b0;
        icb_rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                icb_cmd_ready = ~sys_rst;
                if (accept) state_nxt = RESP;
            end
            RESP: begin
                icb_rsp_valid = ~sys_rst;
                if (icb_rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            icb_rsp_rdata <= 32'h0;
            icb_rsp_err   <= 1'b0;
            con_wr_q      <= 1'b0;
            prd_wr_q      <= 1'b0;
            cnt_wr_q      <= 1'b0;
            icb_wdat      <= 16'h0;
        end else begin
            con_wr_q <= 1'b0;
            prd_wr_q <= 1'b0;
            cnt_wr_q <= 1'b0;
            if (accept) begin
                icb_rsp_err   <= ~req_ok;
                icb_rsp_rdata <= (req_ok & icb_cmd_read) ? {16'h0, rd_val} : 32'h0;
                if (req_ok & ~icb_cmd_read) begin
                    con_wr_q <= sel_con;
                    prd_wr_q <= sel_prd;
                    cnt_wr_q <= sel_cnt;
                    icb_wdat <= icb_cmd_wdata[15:0];
                end
            end
        end
    end

    // Gated by reset so a strobe pending when reset arrives never reaches the timer.
    assign tmr_con_wr = con_wr_q & ~sys_rst;
    assign tmr_prd_wr = prd_wr_q & ~sys_rst;
    assign tmr_cnt_wr = cnt_wr_q & ~sys_rst;

endmodule

// File: tb/tb_tmr_icb_slave.sv
// Directed self-checking bench for tmr_icb_slave; the bench plays both ICB master
// and timer, counting the strobes the timer would see at each clock edge.
module tb_tmr_icb_slave;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;
    logic        tmr_con_wr, tmr_prd_wr, tmr_cnt_wr;
    logic [15:0] icb_wdat;
    logic [15:0] tmr_con, tmr_prd, tmr_cnt;

    int checks = 0;
    int errors = 0;
    int con_wr_n = 0;
    int prd_wr_n = 0;
    int cnt_wr_n = 0;

    tmr_icb_slave dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata),
        .icb_rsp_err   (icb_rsp_err),
        .tmr_con_wr    (tmr_con_wr),
        .tmr_prd_wr    (tmr_prd_wr),
        .tmr_cnt_wr    (tmr_cnt_wr),
        .icb_wdat      (icb_wdat),
        .tmr_con       (tmr_con),
        .tmr_prd       (tmr_prd),
        .tmr_cnt       (tmr_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (tmr_con_wr) con_wr_n <= con_wr_n + 1;
        if (tmr_prd_wr) prd_wr_n <= prd_wr_n + 1;
        if (tmr_cnt_wr) cnt_wr_n <= cnt_wr_n + 1;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [31:0] addr, input logic rd,
                             input logic [31:0] wd, input logic [3:0] wm);
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = addr;
        icb_cmd_read  = rd;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = wm;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (icb_cmd_ready !== 1'b0 || icb_rsp_valid !== 1'b0 ||
                {tmr_con_wr, tmr_prd_wr, tmr_cnt_wr} !== 3'b000 || icb_wdat !== 16'h0) begin
                errors++;
                $display("FAIL reset_state cyc%0d: ready=%b rsp_valid=%b strobes=%b wdat=%h, expected 0 0 000 0000",
                         i, icb_cmd_ready, icb_rsp_valid, {tmr_con_wr, tmr_prd_wr, tmr_cnt_wr}, icb_wdat);
            end
        end
        sys_rst = 1'b0;
        #1;
        checks++;
        if (icb_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", icb_cmd_ready);
        end
    endtask

    task automatic test_write_prd();
        int n0;
        n0 = prd_wr_n;
        icb_rsp_ready = 1'b1;
        drive_cmd(BASE + 32'h4, 1'b0, 32'hABCD_0020, 4'hF);
        tick();
        icb_cmd_valid = 1'b0;
        checks++;
        if ({tmr_con_wr, tmr_prd_wr, tmr_cnt_wr} !== 3'b010 || icb_wdat !== 16'h0020) begin
            errors++;
            $display("FAIL prd_write_strobe: strobes=%b wdat=%h expected 010 0020",
                     {tmr_con_wr, tmr_prd_wr, tmr_cnt_wr}, icb_wdat);
        end
        checks++;
        if (icb_rsp_valid !== 1'b1 || icb_rsp_err !== 1'b0 || icb_rsp_rdata !== 32'h0 || icb_cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL prd_write_rsp: valid=%b err=%b rdata=%h ready=%b expected 1 0 0 0",
                     icb_rsp_valid, icb_rsp_err, icb_rsp_rdata, icb_cmd_ready);
        end
        tick();
        checks++;
        if (tmr_prd_wr !== 1'b0 || icb_rsp_valid !== 1'b0 || icb_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL prd_write_after: prd_wr=%b rsp_valid=%b ready=%b expected 0 0 1",
                     tmr_prd_wr, icb_rsp_valid, icb_cmd_ready);
        end
        tick();
        tick();
        checks++;
        if (icb_wdat !== 16'h0020 || prd_wr_n - n0 !== 1) begin
            errors++;
            $display("FAIL prd_write_hold: wdat=%h strobes_seen=%0d expected 0020 1", icb_wdat, prd_wr_n - n0);
        end
    endtask

    task automatic test_write_con_halfmask();
        int n0;
        n0 = con_wr_n;
        drive_cmd(BASE, 1'b0, 32'hFFFF_5A5A, 4'h3);
        tick();
        icb_cmd_valid = 1'b0;
        checks++;
        if ({tmr_con_wr, tmr_prd_wr, tmr_cnt_wr} !== 3'b100 || icb_wdat !== 16'h5A5A || icb_rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL con_write_mask3: strobes=%b wdat=%h err=%b expected 100 5a5a 0",
                     {tmr_con_wr, tmr_prd_wr, tmr_cnt_wr}, icb_wdat, icb_rsp_err);
        end
        tick();
        checks++;
        if (con_wr_n - n0 !== 1) begin
            errors++;
            $display("FAIL con_write_count: got %0d expected 1", con_wr_n - n0);
        end
    endtask

    task automatic test_read_cnt();
        tmr_cnt = 16'h0011;
        icb_rsp_ready = 1'b0;
        drive_cmd(BASE + 32'h8, 1'b1, 32'h0, 4'h0);
        tick();
        icb_cmd_valid = 1'b0;
        tmr_cnt = 16'h0012;
        checks++;
        if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== 32'h0000_0011 || icb_rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL read_cnt: valid=%b rdata=%h err=%b expected 1 00000011 0",
                     icb_rsp_valid, icb_rsp_rdata, icb_rsp_err);
        end
        tick();
        checks++;
        if (icb_rsp_rdata !== 32'h0000_0011) begin
            errors++;
            $display("FAIL read_cnt_stable: rdata=%h expected 00000011", icb_rsp_rdata);
        end
        icb_rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_pressure();
        tmr_con = 16'h1234;
        tmr_prd = 16'h00AA;
        icb_rsp_ready = 1'b0;
        drive_cmd(BASE, 1'b1, 32'h0, 4'h0);
        tick();
        drive_cmd(BASE + 32'h4, 1'b1, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== 32'h0000_1234 || icb_cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure cyc%0d: valid=%b rdata=%h ready=%b expected 1 00001234 0",
                         i, icb_rsp_valid, icb_rsp_rdata, icb_cmd_ready);
            end
            tick();
        end
        icb_rsp_ready = 1'b1;
        #1;
        checks++;
        if (icb_cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release_ready: got %b expected 0", icb_cmd_ready);
        end
        tick();
        checks++;
        if (icb_cmd_ready !== 1'b1 || icb_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_idle: ready=%b valid=%b expected 1 0", icb_cmd_ready, icb_rsp_valid);
        end
        tick();
        icb_cmd_valid = 1'b0;
        checks++;
        if (icb_rsp_valid !== 1'b1 || icb_rsp_rdata !== 32'h0000_00AA) begin
            errors++;
            $display("FAIL second_cmd: valid=%b rdata=%h expected 1 000000aa", icb_rsp_valid, icb_rsp_rdata);
        end
        tick();
    endtask

    task automatic test_errors();
        logic [31:0] addrs [4];
        logic        rds   [4];
        logic [3:0]  wms   [4];
        int          s0;
        addrs = '{BASE + 32'hC, BASE + 32'h2, BASE + 32'h1000, BASE};
        rds   = '{1'b0, 1'b1, 1'b0, 1'b0};
        wms   = '{4'hF, 4'hF, 4'hF, 4'h1};
        tmr_con = 16'hBEEF;
        tmr_prd = 16'hCAFE;
        tmr_cnt = 16'hF00D;
        icb_rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s0 = con_wr_n + prd_wr_n + cnt_wr_n;
            drive_cmd(addrs[i], rds[i], 32'h0000_9999, wms[i]);
            tick();
            icb_cmd_valid = 1'b0;
            checks++;
            if (icb_rsp_valid !== 1'b1 || icb_rsp_err !== 1'b1 || icb_rsp_rdata !== 32'h0) begin
                errors++;
                $display("FAIL err_rsp%0d: valid=%b err=%b rdata=%h expected 1 1 00000000",
                         i, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata);
            end
            tick();
            checks++;
            if (con_wr_n + prd_wr_n + cnt_wr_n !== s0 || icb_wdat !== 16'h5A5A) begin
                errors++;
                $display("FAIL err_nostrobe%0d: strobes=%0d wdat=%h expected 0 5a5a",
                         i, con_wr_n + prd_wr_n + cnt_wr_n - s0, icb_wdat);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        n0 = con_wr_n;
        icb_rsp_ready = 1'b0;
        drive_cmd(BASE, 1'b0, 32'h0000_0077, 4'hF);
        tick();
        icb_cmd_valid = 1'b0;
        sys_rst = 1'b1;
        #1;
        checks++;
        if (tmr_con_wr !== 1'b0 || icb_cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_gate: con_wr=%b ready=%b expected 0 0", tmr_con_wr, icb_cmd_ready);
        end
        tick();
        checks++;
        if (icb_rsp_valid !== 1'b0 || tmr_con_wr !== 1'b0 || icb_wdat !== 16'h0 || icb_rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL midrst_after: valid=%b con_wr=%b wdat=%h rdata=%h expected 0 0 0000 0",
                     icb_rsp_valid, tmr_con_wr, icb_wdat, icb_rsp_rdata);
        end
        sys_rst = 1'b0;
        icb_rsp_ready = 1'b1;
        tick();
        checks++;
        if (con_wr_n !== n0 || icb_rsp_valid !== 1'b0 || icb_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_nowrite: writes=%0d valid=%b ready=%b expected 0 0 1",
                     con_wr_n - n0, icb_rsp_valid, icb_cmd_ready);
        end
    endtask

    initial begin
        sys_rst       = 1'b1;
        icb_cmd_valid = 1'b0;
        icb_cmd_addr  = 32'h0;
        icb_cmd_read  = 1'b0;
        icb_cmd_wdata = 32'h0;
        icb_cmd_wmask = 4'h0;
        icb_rsp_ready = 1'b1;
        tmr_con       = 16'h0;
        tmr_prd       = 16'h0;
        tmr_cnt       = 16'h0;
        #1;
        test_reset();
        test_write_prd();
        test_write_con_halfmask();
        test_read_cnt();
        test_back_pressure();
        test_errors();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tmr_icb_slave.md
Name: tmr_icb_slave

Overview:
ICB slave register front-end that sits directly upstream of the 16-bit timer. It decodes single-beat ICB command transactions and converts writes into the timer's one-cycle write strobes (tmr_con_wr, tmr_prd_wr, tmr_cnt_wr) with icb_wdat. It serves reads from the timer's tmr_con/tmr_prd/tmr_cnt outputs and returns ICB responses, one transaction outstanding at a time.

Parameters:
BASE_ADDR, 32'h1000_0000, base of the 4 KB timer register window; must be 4 KB aligned.
CON_OFS, 12'h000, byte offset of the TMR_CON register.
PRD_OFS, 12'h004, byte offset of the TMR_PRD register.
CNT_OFS, 12'h008, byte offset of the TMR_CNT register.

Ports:
sys_clk  in  1  single clock; shared with the timer.
sys_rst  in  1  synchronous reset, active-high.
icb_cmd_valid  in  1  command valid.
icb_cmd_ready  out  1  command accepted when high together with valid.
icb_cmd_addr  in  32  byte address.
icb_cmd_read  in  1  1=read, 0=write.
icb_cmd_wdata  in  32  write data.
icb_cmd_wmask  in  4  byte write mask.
icb_rsp_valid  out  1  response valid.
icb_rsp_ready  in  1  response accepted.
icb_rsp_rdata  out  32  read data; zero-extended 16-bit register value.
icb_rsp_err  out  1  error response.
tmr_con_wr  out  1  one-cycle write strobe to the timer CON register.
tmr_prd_wr  out  1  one-cycle write strobe to the timer PRD register.
tmr_cnt_wr  out  1  one-cycle write strobe to the timer CNT register.
icb_wdat  out  16  write data to the timer.
tmr_con  in  16  timer CON readback.
tmr_prd  in  16  timer PRD readback.
tmr_cnt  in  16  timer CNT readback.

Behaviour:
- FSM states: IDLE and RESP.
  - icb_cmd_ready = 1 only in IDLE while sys_rst is low.
  - Accept = icb_cmd_valid & icb_cmd_ready.
  - Accept moves IDLE->RESP.
  - icb_rsp_valid & icb_rsp_ready moves RESP->IDLE.
- Reset (sys_rst=1 at a sys_clk edge):
  - State returns to IDLE.
  - icb_rsp_valid=0, icb_rsp_rdata=0, icb_rsp_err=0.
  - All tmr_*_wr=0, icb_wdat=16'h0.
  - icb_cmd_ready=0 while sys_rst is high.
  - Reset mid-transaction discards any pending response and any pending strobe; no strobe fires after reset.
- Decode, evaluated at the accept edge:
  - hit = (addr[31:12]==BASE_ADDR[31:12]).
  - ofs = addr[11:0].
  - A request is valid only if hit, ofs is one of CON_OFS/PRD_OFS/CNT_OFS, and addr[1:0]==0.
  - Writes additionally require wmask[1:0]==2'b11; wmask[3:2] is ignored.
  - Any other request gets icb_rsp_err=1, icb_rsp_rdata=0, and produces no strobe.
- Write timing:
  - In the cycle after accept, exactly one matching tmr_*_wr is high for one sys_clk cycle.
  - In that same cycle icb_wdat = wdata[15:0].
  - icb_wdat holds its value until the next valid write; it is not cleared.
  - wdata[31:16] is ignored.
  - Write response: rdata=0, err=0.
- Read timing:
  - The selected tmr_* value is sampled at the accept edge.
  - rdata = {16'h0, value}.
  - Later counter movement does not alter a pending response.
- Response timing:
  - icb_rsp_valid rises in the cycle after accept, the same cycle as any strobe; latency is 1.
  - icb_rsp_rdata and icb_rsp_err hold stable while valid & !ready.
- Throughput:
  - The earliest next accept is the cycle after the response handshake, so minimum 2 cycles per transaction with rsp_ready tied high.
  - Back-pressure on rsp_ready stalls the command channel with cmd_ready=0.
- Strobes are mutually exclusive; at most one strobe per transaction.
- A command presented during RESP is not accepted and must be held by the master.

Test Plan:
- Reset: assert sys_rst 3 cycles, then release -> during reset cmd_ready=0, rsp_valid=0, all strobes 0, icb_wdat=0; cmd_ready=1 in the first cycle after release.
- Write PRD: addr=BASE+4, wdata=32'hABCD_0020, wmask=4'hF, rsp_ready=1 -> cycle after accept: tmr_prd_wr=1 for exactly one cycle, icb_wdat=16'h0020, rsp_valid=1 with err=0; icb_wdat is still 16'h0020 3 cycles later.
- Read CNT while the timer runs: tmr_cnt=16'h0011 at the accept edge, 16'h0012 the next cycle -> rdata=32'h0000_0011, err=0.
- Back-pressure: read CON with rsp_ready=0 for 5 cycles -> rsp_valid and rdata stable for 5 cycles, cmd_ready=0 throughout, a second command is not accepted until the cycle after rsp_ready=1.
- Errors, one per transaction, each with no strobe:
  - addr=BASE+0xC -> err=1, rdata=0.
  - addr=BASE+0x2 -> err=1, rdata=0.
  - addr=BASE+0x1000 -> err=1, rdata=0.
  - write CON with wmask=4'h1 -> err=1.
- Reset mid-transaction: assert sys_rst in the cycle after a CON write is accepted -> rsp_valid=0 and tmr_con_wr=0 in the following cycle; the timer sees no write.
